// File: rtl/sd_clock_ctrl.sv
// sd_clock_ctrl: sequences SD clock divider changes so the card clock never
// sees a glitch or runt pulse. Starts at INIT_DIV. Later divider changes are
// taken only while the bus is idle. The card clock is gated off while the
// clock is low, the divider is reloaded, and the clock is re-enabled after it
// has settled.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   REQ_VALID  divider change request, held until accepted
//   REQ_DIV    requested divider, stable while REQ_VALID
//   REQ_READY  request accepted on an edge where REQ_VALID & REQ_READY
//              (combinational)
//   BUS_BUSY   transfer in progress; blocks acceptance
//   SD_CLK_IN  divider output fed back, synchronous to CLK
//   DIVIDER    divider value driven to the clock divider
//   DIV_RST    clock divider reset (divider output held low)
//   CLK_EN     card clock gate enable
//   DONE       one-cycle pulse: requested divider active, card clock running
module sd_clock_ctrl #(
   parameter logic [7:0] INIT_DIV     = 8'd124,
   parameter logic [7:0] SETTLE_EDGES = 8'd8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ_VALID,
   input  logic [7:0] REQ_DIV,
   output logic       REQ_READY,
   input  logic       BUS_BUSY,
   input  logic       SD_CLK_IN,
   output logic [7:0] DIVIDER,
   output logic       DIV_RST,
   output logic       CLK_EN,
   output logic       DONE
);

   localparam int unsigned DIV_W = 8;
   localparam logic [DIV_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_INIT,
      S_RUN,
      S_DRAIN,
      S_LOAD,
      S_SETTLE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DIV_W-1:0]  pending;
   logic [DIV_W-1:0]  pending_nxt;
   logic [DIV_W-1:0]  count;
   logic [DIV_W-1:0]  count_nxt;
   logic [DIV_W-1:0]  divider_nxt;
   logic              div_rst_nxt;
   logic              clk_en_nxt;
   logic              done_nxt;
   logic              sd_prev;
   logic              sd_rise;
   logic              settled;
   logic              take;

   // Rising edge of the fed-back SD clock, and "settled and clock low" point.
   assign sd_rise = !sd_prev && SD_CLK_IN;
   assign settled = (count >= SETTLE_EDGES) && !SD_CLK_IN;
   assign take    = REQ_VALID && !BUS_BUSY;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_INIT;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:   state_nxt = S_SETTLE;
         S_RUN:    if (take && (REQ_DIV != DIVIDER)) state_nxt = S_DRAIN;
         S_DRAIN:  if (!SD_CLK_IN) state_nxt = S_LOAD;
         S_LOAD:   state_nxt = S_SETTLE;
         S_SETTLE: if (settled) state_nxt = S_RUN;
         default:  state_nxt = S_INIT;
      endcase
   end

   // Output logic: ready strobe plus next values of the registered outputs.
   always_comb begin
      REQ_READY   = 1'b0;
      divider_nxt = DIVIDER;
      div_rst_nxt = DIV_RST;
      clk_en_nxt  = CLK_EN;
      done_nxt    = 1'b0;
      pending_nxt = pending;
      count_nxt   = count;
      case (state)
         S_INIT: div_rst_nxt = 1'b0;
         S_RUN: begin
            REQ_READY = !BUS_BUSY;
            if (take) begin
               // Same divider: nothing to reload, acknowledge immediately.
               if (REQ_DIV == DIVIDER) done_nxt    = 1'b1;
               else                    pending_nxt = REQ_DIV;
            end
         end
         S_DRAIN: begin
            // Gate off and reload only while the card clock is low.
            if (!SD_CLK_IN) begin
               clk_en_nxt  = 1'b0;
               divider_nxt = pending;
               div_rst_nxt = 1'b1;
            end
         end
         S_LOAD: begin
            div_rst_nxt = 1'b0;
            count_nxt   = '0;
         end
         S_SETTLE: begin
            if (sd_rise && (count != CNT_MAX)) count_nxt = count + DIV_W'(1);
            if (settled) begin
               clk_en_nxt = 1'b1;
               done_nxt   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         DIVIDER <= INIT_DIV;
         DIV_RST <= 1'b1;
         CLK_EN  <= 1'b0;
         DONE    <= 1'b0;
         pending <= INIT_DIV;
         count   <= '0;
         sd_prev <= 1'b0;
      end else begin
         DIVIDER <= divider_nxt;
         DIV_RST <= div_rst_nxt;
         CLK_EN  <= clk_en_nxt;
         DONE    <= done_nxt;
         pending <= pending_nxt;
         count   <= count_nxt;
         sd_prev <= SD_CLK_IN;
      end
   end

endmodule

// File: tb/tb_sd_clock_ctrl.sv
// Testbench for sd_clock_ctrl with a behavioural clock divider in the loop.
`timescale 1ns/1ps
module tb_sd_clock_ctrl;

   localparam logic [7:0] INIT_DIV     = 8'd4;
   localparam logic [7:0] SETTLE_EDGES = 8'd2;

   logic       CLK       = 1'b0;
   logic       RST       = 1'b1;
   logic       REQ_VALID = 1'b0;
   logic [7:0] REQ_DIV   = 8'd0;
   logic       BUS_BUSY  = 1'b0;
   logic       SD_CLK_IN = 1'b0;
   logic       REQ_READY;
   logic [7:0] DIVIDER;
   logic       DIV_RST;
   logic       CLK_EN;
   logic       DONE;

   int errors = 0;
   int checks = 0;
   int model_div = INIT_DIV;

   always #5 CLK = ~CLK;

   sd_clock_ctrl #(.INIT_DIV(INIT_DIV), .SETTLE_EDGES(SETTLE_EDGES)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DIV(REQ_DIV),
      .REQ_READY(REQ_READY), .BUS_BUSY(BUS_BUSY), .SD_CLK_IN(SD_CLK_IN),
      .DIVIDER(DIVIDER), .DIV_RST(DIV_RST), .CLK_EN(CLK_EN), .DONE(DONE)
   );

   // Clock divider: toggles when its counter reaches DIVIDER, held low in reset.
   logic [7:0] div_cnt = 8'd0;
   always @(posedge CLK or posedge RST) begin
      if (RST || DIV_RST) begin
         div_cnt   <= 8'd0;
         SD_CLK_IN <= 1'b0;
      end else if (div_cnt == DIVIDER) begin
         div_cnt   <= 8'd0;
         SD_CLK_IN <= ~SD_CLK_IN;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   // Observers: DONE pulses, DIV_RST cycles, gate changes while the clock is
   // high, and enables that come before enough settle edges were seen.
   int   done_cnt   = 0;
   int   divrst_cnt = 0;
   int   glitch_cnt = 0;
   int   settle_bad = 0;
   int   rises      = 0;
   logic prev_en    = 1'b0;
   logic prev_sd    = 1'b0;
   always @(negedge CLK) begin
      prev_en <= CLK_EN;
      prev_sd <= SD_CLK_IN;
      if (RST) begin
         rises <= 0;
      end else begin
         if (DONE) done_cnt <= done_cnt + 1;
         if (DIV_RST) divrst_cnt <= divrst_cnt + 1;
         if ((CLK_EN != prev_en) && prev_sd) glitch_cnt <= glitch_cnt + 1;
         if (DIV_RST) rises <= 0;
         else if (SD_CLK_IN && !prev_sd) rises <= rises + 1;
         if (CLK_EN && !prev_en && (rises < int'(SETTLE_EDGES))) settle_bad <= settle_bad + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_req(input logic [7:0] div, input bit rand_busy,
                           output bit ok, output int waits);
      ok    = 1'b0;
      waits = 0;
      @(negedge CLK);
      REQ_VALID = 1'b1;
      REQ_DIV   = div;
      for (int i = 0; i < 2000; i++) begin
         if (rand_busy) BUS_BUSY = ($urandom_range(0, 2) == 0);
         #1;
         if (REQ_READY) begin
            ok = 1'b1;
            break;
         end
         waits++;
         @(negedge CLK);
      end
      if (ok) @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (DONE) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic measure_period(output int p);
      int   first;
      logic last;
      p     = -1;
      first = -1;
      last  = SD_CLK_IN;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (SD_CLK_IN && !last) begin
            if (first < 0) first = i;
            else begin
               p = i - first;
               break;
            end
         end
         last = SD_CLK_IN;
      end
   endtask

   task automatic test_reset();
      int d0;
      int p;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      checks++; if (DIVIDER !== INIT_DIV) begin errors++; $display("FAIL rst_divider: got %0d expected %0d", DIVIDER, INIT_DIV); end
      checks++; if (DIV_RST !== 1'b1) begin errors++; $display("FAIL rst_div_rst: got %b expected 1", DIV_RST); end
      checks++; if (CLK_EN !== 1'b0) begin errors++; $display("FAIL rst_clk_en: got %b expected 0", CLK_EN); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", DONE); end
      checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", REQ_READY); end
      d0 = done_cnt;
      RST = 1'b0;
      model_div = INIT_DIV;
      repeat (25) @(negedge CLK);
      #1;
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rst_done_count: got %0d expected 1", done_cnt - d0); end
      checks++; if (CLK_EN !== 1'b1) begin errors++; $display("FAIL rst_clk_en_after: got %b expected 1", CLK_EN); end
      measure_period(p);
      checks++; if (p !== 10) begin errors++; $display("FAIL rst_period: got %0d expected 10", p); end
   endtask

   task automatic test_div_zero();
      int d0, r0, waits, p;
      bit ok;
      d0 = done_cnt;
      r0 = divrst_cnt;
      send_req(8'd0, 1'b0, ok, waits);
      checks++; if (!ok || waits != 0) begin errors++; $display("FAIL div0_accept: got ok=%0d waits=%0d expected ok=1 waits=0", ok, waits); end
      model_div = 0;
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL div0_done_timeout: got no DONE expected DONE within 200 cycles"); end
      @(negedge CLK);
      #1;
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL div0_done_count: got %0d expected 1", done_cnt - d0); end
      checks++; if (divrst_cnt - r0 !== 1) begin errors++; $display("FAIL div0_div_rst_cycles: got %0d expected 1", divrst_cnt - r0); end
      checks++; if (DIVIDER !== 8'd0) begin errors++; $display("FAIL div0_divider: got %0d expected 0", DIVIDER); end
      checks++; if (CLK_EN !== 1'b1) begin errors++; $display("FAIL div0_clk_en: got %b expected 1", CLK_EN); end
      measure_period(p);
      checks++; if (p !== 2) begin errors++; $display("FAIL div0_period: got %0d expected 2", p); end
   endtask

   task automatic test_same_div();
      int d0, r0, waits;
      bit ok;
      send_req(8'd4, 1'b0, ok, waits);
      model_div = 4;
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL same_setup_timeout: got no DONE expected DONE"); end
      repeat (2) @(negedge CLK);
      d0 = done_cnt;
      r0 = divrst_cnt;
      send_req(8'd4, 1'b0, ok, waits);
      @(negedge CLK);
      checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL same_done_t1: got %b expected 1", DONE); end
      checks++; if (CLK_EN !== 1'b1 || DIV_RST !== 1'b0) begin errors++; $display("FAIL same_gate: got en=%b div_rst=%b expected en=1 div_rst=0", CLK_EN, DIV_RST); end
      checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL same_ready: got %b expected 1", REQ_READY); end
      @(negedge CLK);
      #1;
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL same_done_pulse: got %b expected 0", DONE); end
      checks++; if (done_cnt - d0 !== 1 || divrst_cnt - r0 !== 0) begin errors++; $display("FAIL same_counts: got done=%0d div_rst=%0d expected done=1 div_rst=0", done_cnt - d0, divrst_cnt - r0); end
   endtask

   task automatic test_busy();
      int bad;
      bit ok;
      bad = 0;
      @(negedge CLK);
      BUS_BUSY  = 1'b1;
      REQ_VALID = 1'b1;
      REQ_DIV   = 8'd7;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (REQ_READY !== 1'b0 || DIVIDER !== 8'd4) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL busy_block: got %0d bad cycles expected 0", bad); end
      BUS_BUSY = 1'b0;
      #1;
      checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL busy_release_ready: got %b expected 1", REQ_READY); end
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      model_div = 7;
      @(negedge CLK);
      checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL busy_accepted: got ready=%b expected 0 (change in progress)", REQ_READY); end
      wait_done(200, ok);
      checks++; if (!ok || DIVIDER !== 8'd7) begin errors++; $display("FAIL busy_final: got ok=%0d divider=%0d expected ok=1 divider=7", ok, DIVIDER); end
   endtask

   task automatic test_reset_mid();
      int waits, p;
      bit ok, seen;
      send_req(8'd9, 1'b0, ok, waits);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (DIV_RST) begin seen = 1'b1; break; end
      end
      for (int i = 0; i < 5 && DIV_RST; i++) @(negedge CLK);
      repeat (3) @(negedge CLK);
      checks++; if (!seen || CLK_EN !== 1'b0) begin errors++; $display("FAIL mid_in_settle: got seen=%0d en=%b expected seen=1 en=0", seen, CLK_EN); end
      #2;
      RST = 1'b1;
      #1;
      checks++; if (DIVIDER !== INIT_DIV || DIV_RST !== 1'b1) begin errors++; $display("FAIL mid_rst_div: got divider=%0d div_rst=%b expected divider=%0d div_rst=1", DIVIDER, DIV_RST, INIT_DIV); end
      checks++; if (CLK_EN !== 1'b0 || DONE !== 1'b0 || REQ_READY !== 1'b0) begin errors++; $display("FAIL mid_rst_outs: got en=%b done=%b ready=%b expected 0 0 0", CLK_EN, DONE, REQ_READY); end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      model_div = INIT_DIV;
      wait_done(100, ok);
      checks++; if (!ok || DIVIDER !== INIT_DIV) begin errors++; $display("FAIL mid_restart: got ok=%0d divider=%0d expected ok=1 divider=%0d", ok, DIVIDER, INIT_DIV); end
      send_req(8'd9, 1'b0, ok, waits);
      model_div = 9;
      wait_done(300, ok);
      checks++; if (!ok || DIVIDER !== 8'd9) begin errors++; $display("FAIL mid_reissue: got ok=%0d divider=%0d expected ok=1 divider=9", ok, DIVIDER); end
      measure_period(p);
      checks++; if (p !== 20) begin errors++; $display("FAIL mid_period: got %0d expected 20", p); end
   endtask

   task automatic test_random();
      int d0, r0, accepts, exp_rst, timeouts, waits;
      logic [7:0] div;
      bit ok;
      d0 = done_cnt;
      r0 = divrst_cnt;
      accepts = 0;
      exp_rst = 0;
      timeouts = 0;
      for (int n = 0; n < 20; n++) begin
         div = 8'($urandom_range(0, 7));
         send_req(div, 1'b1, ok, waits);
         if (!ok) timeouts++;
         else begin
            accepts++;
            if (int'(div) != model_div) exp_rst++;
            model_div = int'(div);
         end
      end
      BUS_BUSY = 1'b0;
      for (int i = 0; i < 500 && (done_cnt - d0 < accepts); i++) @(negedge CLK);
      repeat (3) @(negedge CLK);
      #1;
      checks++; if (timeouts != 0) begin errors++; $display("FAIL rand_accept_timeout: got %0d timeouts expected 0", timeouts); end
      checks++; if (done_cnt - d0 != accepts) begin errors++; $display("FAIL rand_done_count: got %0d expected %0d", done_cnt - d0, accepts); end
      checks++; if (divrst_cnt - r0 != exp_rst) begin errors++; $display("FAIL rand_div_rst_cycles: got %0d expected %0d", divrst_cnt - r0, exp_rst); end
      checks++; if (int'(DIVIDER) != model_div) begin errors++; $display("FAIL rand_final_divider: got %0d expected %0d", DIVIDER, model_div); end
      checks++; if (glitch_cnt != 0) begin errors++; $display("FAIL gate_change_while_high: got %0d expected 0", glitch_cnt); end
      checks++; if (settle_bad != 0) begin errors++; $display("FAIL enable_before_settle: got %0d expected 0", settle_bad); end
   endtask

   initial begin
      test_reset();
      test_div_zero();
      test_same_div();
      test_busy();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sd_clock_ctrl.md
# sd_clock_ctrl

Sequencer for the SD clock divider: owns the divider's DIVIDER and reset inputs and the card clock-gate enable, and changes the SD clock frequency on request without glitches or runt pulses on the card clock. Sits between the host command/data engines and the divider. Starts at a fixed initial divider (identification speed) and switches to requested dividers only when the bus is idle.

## Interface
- INIT_DIV, 8'd124: divider loaded at reset.
- SETTLE_EDGES, 8'd8: SD_CLK_IN rising edges counted after a divider load before the card clock is re-enabled.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  divider change request; held until accepted.
- REQ_DIV  in  8  requested divider; stable while REQ_VALID=1.
- REQ_READY  out  1  request accepted on edge where REQ_VALID & REQ_READY.
- BUS_BUSY  in  1  command/data transfer in progress; blocks acceptance.
- SD_CLK_IN  in  1  divider output fed back; synchronous to CLK.
- DIVIDER  out  8  divider value driven to the clock divider.
- DIV_RST  out  1  reset to the clock divider (divider output forced 0 while high).
- CLK_EN  out  1  card clock gate enable.
- DONE  out  1  one-cycle pulse: requested divider active and card clock running.

## Operation
- Divider behaviour: SD_CLK toggles when its counter reaches DIVIDER; period 2*(DIVIDER+1) CLK cycles; SD_CLK=0 while DIV_RST=1.
- Reset values: state INIT, DIVIDER=INIT_DIV, DIV_RST=1, CLK_EN=0, DONE=0, pending=INIT_DIV, edge count=0, sd_prev=0. REQ_READY=0.
- States:
  - INIT: one cycle after reset release with DIV_RST=1; -> SETTLE, DIV_RST<=0.
  - RUN: REQ_READY = !BUS_BUSY (combinational). On accept: if REQ_DIV==DIVIDER, DONE<=1, stay RUN (no DIV_RST, no CLK_EN change); else pending<=REQ_DIV, -> DRAIN.
  - DRAIN: wait for an edge with SD_CLK_IN==0; at that edge CLK_EN<=0, DIVIDER<=pending, DIV_RST<=1, -> LOAD.
  - LOAD: exactly one cycle; DIV_RST<=0, count<=0, -> SETTLE.
  - SETTLE: count increments (saturating at 255) on each edge where sd_prev==0 && SD_CLK_IN==1. At first edge where count>=SETTLE_EDGES and SD_CLK_IN==0: CLK_EN<=1, DONE<=1, -> RUN.
- sd_prev registers SD_CLK_IN every cycle.
- DONE cleared every cycle it is not set.
- CLK_EN only changes at edges where SD_CLK_IN==0 (glitch-free gate).
- REQ_VALID outside RUN is ignored; it stays pending at the requester.
- BUS_BUSY rising after acceptance does not abort the change.
- DIVIDER=0 is legal (SD_CLK toggles every CLK).
- SETTLE_EDGES=0: enable at first SETTLE edge with SD_CLK_IN==0.

## Timing
- Accept edge t0 -> DRAIN active from t0+1; DRAIN length 1 cycle if SD_CLK_IN low, else until it goes low (at most DIVIDER+1 cycles).
- DIV_RST high exactly one cycle per change (the LOAD cycle); DIVIDER updates the same edge DIV_RST rises.
- Same-divider request: DONE at t0+1, REQ_READY remains high.
- RST asserted in any state: outputs take reset values immediately (asynchronous). Pending request is discarded. Sequence restarts at INIT after release.
- Exactly one DONE pulse per accepted request and one after each reset.

## Test plan
- Reset, INIT_DIV=4, SETTLE_EDGES=2, CLK period 10: during RST, DIVIDER=4, DIV_RST=1, CLK_EN=0, DONE=0. After release, exactly one DONE within 25 cycles; CLK_EN=1 thereafter; SD_CLK_IN period 10 cycles.
- From RUN, request REQ_DIV=0, BUS_BUSY=0: accepted next edge, DIV_RST high exactly 1 cycle, DIVIDER=0, CLK_EN low until 2 rising edges seen, then DONE once; SD_CLK_IN period 2 cycles.
- Request REQ_DIV=4 while DIVIDER=4: DONE at t0+1, CLK_EN stays 1, DIV_RST stays 0.
- BUS_BUSY=1 with REQ_VALID=1 for 50 cycles: REQ_READY=0, DIVIDER unchanged. Drop BUS_BUSY: accepted at next edge.
- Assert RST mid-SETTLE after request REQ_DIV=9: outputs return to reset values within the same cycle, DIVIDER=INIT_DIV. The change completes normally after the request is reissued.
- 20 random REQ_DIV requests with random BUS_BUSY: CLK_EN never toggles in a cycle with SD_CLK_IN=1; one DONE per accept; final DIVIDER equals last REQ_DIV.
